// File: rtl/multicycle_datapath_if.sv
// Memory-side handshake bundle for the multi-cycle core.
// The core drives requests; the memories answer with ack and data.
interface multicycle_datapath_if #(
  parameter int DATA_W = 16,
  parameter int PC_W = 16
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle core for the 16-bit ISA with parametrised widths.
// Fetch and data accesses stall on req/ack until the memory answers.
module multicycle_datapath #(
  parameter int DATA_W = 16,
  parameter int PC_W = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_datapath_if.master bus,
  output logic [PC_W-1:0]      pc,
  output logic                 halted,
  output logic [31:0]          retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_nx;

  logic [15:0]       ir;
  logic [DATA_W-1:0] a, b, alu, alu_q, mdr;
  logic [DATA_W-1:0] regs [8];

  logic [3:0] op;
  logic [2:0] rs, rt, rd, funct;
  logic [DATA_W-1:0] imm;

  assign op    = ir[15:12];
  assign rs    = ir[11:9];
  assign rt    = ir[8:6];
  assign rd    = ir[5:3];
  assign funct = ir[2:0];
  assign imm   = {{(DATA_W-6){ir[5]}}, ir[5:0]};

  logic is_lw, is_sw, is_r, is_addi;
  logic is_beq, is_bne, is_jmp, is_halt;
  logic is_mem, is_wb;

  assign is_lw   = op == 4'h0;
  assign is_sw   = op == 4'h1;
  assign is_r    = op == 4'h2;
  assign is_addi = op == 4'h3;
  assign is_beq  = op == 4'hb;
  assign is_bne  = op == 4'hc;
  assign is_jmp  = op == 4'hd;
  assign is_halt = op == 4'hf;
  assign is_mem  = is_lw | is_sw;
  assign is_wb   = is_r | is_addi;

  always_comb begin
    alu = a + imm;
    if (is_r) begin
      unique case (funct)
        3'd0: alu = a + b;
        3'd1: alu = a - b;
        3'd2: alu = a & b;
        3'd3: alu = a | b;
        3'd4: alu = a ^ b;
        3'd5: alu = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
        3'd6: alu = {a[DATA_W-2:0], 1'b0};
        3'd7: alu = {1'b0, a[DATA_W-1:1]};
      endcase
    end
  end

  logic [PC_W-1:0] pc2, br_off, pc_exec;
  logic            taken;

  assign pc2    = pc + PC_W'(2);
  assign br_off = {{(PC_W-7){ir[5]}}, ir[5:0], 1'b0};
  assign taken  = (is_beq && a == b) || (is_bne && a != b);

  // Jumps keep the top region bits of pc+2 and replace the rest.
  always_comb begin
    pc_exec = pc2;
    unique case (1'b1)
      taken:   pc_exec = pc2 + br_off;
      is_jmp:  pc_exec = {pc2[PC_W-1:13], ir[11:0], 1'b0};
      default: ;
    endcase
  end

  logic [2:0]        wr_idx;
  logic [DATA_W-1:0] wb_val;

  assign wr_idx = is_r ? rd : rt;
  assign wb_val = is_lw ? mdr : alu_q;

  logic ireq, dreq, retire;

  always_comb begin
    state_nx = state;
    ireq     = 1'b0;
    dreq     = 1'b0;
    retire   = 1'b0;
    unique case (state)
      S_FETCH: begin
        ireq = 1'b1;
        if (bus.imem_ack) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_mem: state_nx = S_MEM;
          is_wb:  state_nx = S_WB;
          is_halt: begin
            state_nx = S_HALT;
            retire   = 1'b1;
          end
          default: begin
            state_nx = S_FETCH;
            retire   = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        dreq = 1'b1;
        if (bus.dmem_ack) begin
          state_nx = is_lw ? S_WB : S_FETCH;
          retire   = ~is_lw;
        end
      end
      S_WB: begin
        state_nx = S_FETCH;
        retire   = 1'b1;
      end
      S_HALT: ;
      default: state_nx = S_FETCH;
    endcase
  end

  // Requests are masked while reset is held, whatever the state.
  assign bus.imem_req   = ireq & ~rst;
  assign bus.dmem_req   = dreq & ~rst;
  assign bus.imem_addr  = pc;
  assign bus.dmem_we    = is_sw;
  assign bus.dmem_addr  = alu_q;
  assign bus.dmem_wdata = b;
  assign halted         = state == S_HALT;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= PC_W'(RESET_PC);
      retired <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_q   <= '0;
      mdr     <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (retire) retired <= retired + 32'd1;
      unique case (state)
        S_FETCH: if (bus.imem_ack) ir <= bus.imem_rdata;
        S_DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
        end
        S_EXEC: begin
          alu_q <= alu;
          if (!is_mem && !is_wb && !is_halt) pc <= pc_exec;
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            if (is_lw) mdr <= bus.dmem_rdata;
            else       pc  <= pc2;
          end
        end
        S_WB: begin
          if (wr_idx != 3'd0) regs[wr_idx] <= wb_val;
          pc <= pc2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: ISA-level model plus memory responders
// with wait states, directed program then randomized programs.
module tb_multicycle_datapath;
  localparam int DW = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pc;
  logic          halted;
  logic [31:0]   retired;

  multicycle_datapath_if #(.DATA_W(DW), .PC_W(PW)) bus();

  multicycle_datapath #(.DATA_W(DW), .PC_W(PW), .RESET_PC(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .pc(pc),
    .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [15:0] imem [4096];
  logic [15:0] dm [logic [15:0]];

  logic [15:0] mr [8];
  logic [15:0] m_pc;
  logic [31:0] exp_ret;
  bit          halt_m;
  int          fetch_at, mem_at, ret_at, halt_at;
  int          iw, dw;
  bit          m_we;
  logic [15:0] m_addr, m_wdata, m_ld;

  bit          directed;
  bit          mid_rst_req, mid_fire;
  logic [15:0] lit_fetch [$];
  logic [31:0] lit_st [$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
  endtask

  function automatic logic [15:0] sx6(input logic [15:0] ins);
    return {{10{ins[5]}}, ins[5:0]};
  endfunction

  function automatic logic [15:0] f_alu(input logic [2:0] fn,
                                        input logic [15:0] x, y);
    case (fn)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      3'd6: return x << 1;
      default: return x >> 1;
    endcase
  endfunction

  function automatic logic [15:0] f_npc(input logic [15:0] p, ins,
                                        input bit eq);
    logic [15:0] p2;
    p2 = p + 16'd2;
    case (ins[15:12])
      4'hb: return eq ? p2 + (sx6(ins) << 1) : p2;
      4'hc: return !eq ? p2 + (sx6(ins) << 1) : p2;
      4'hd: return {p2[15:13], ins[11:0], 1'b0};
      4'hf: return p;
      default: return p2;
    endcase
  endfunction

  function automatic logic [15:0] dm_rd(input logic [15:0] ad);
    return dm.exists(ad) ? dm[ad] : (ad ^ 16'ha5c3);
  endfunction

  function automatic int pick_iw();
    if (directed) return 0;
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  function automatic int pick_dw();
    return directed ? 3 : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [15:0] rnd_ins();
    int unsigned r;
    logic [3:0]  op;
    r = $urandom_range(0, 31);
    if (r < 4)       op = 4'h0;
    else if (r < 8)  op = 4'h1;
    else if (r < 16) op = 4'h2;
    else if (r < 22) op = 4'h3;
    else if (r < 25) op = 4'hb;
    else if (r < 28) op = 4'hc;
    else if (r == 28) op = 4'hd;
    else if (r == 29) op = 4'($urandom_range(4, 10));
    else if (r == 30) op = 4'he;
    else op = ($urandom_range(0, 3) == 0) ? 4'hf : 4'h3;
    return {op, 12'($urandom)};
  endfunction

  task automatic wr(input logic [2:0] idx, input logic [15:0] v);
    if (idx != 3'd0) mr[idx] = v;
  endtask

  // Executes one whole instruction at fetch time and schedules when
  // its bus activity and retirement must appear.
  task automatic model_exec(input logic [15:0] ins);
    logic [15:0] x, y, im;
    int base;
    bit memop, hlt;
    x = mr[ins[11:9]];
    y = mr[ins[8:6]];
    im = sx6(ins);
    base = 3;
    memop = 0;
    hlt = 0;
    case (ins[15:12])
      4'h0: begin
        m_addr = x + im; m_we = 0; m_wdata = y;
        m_ld = dm_rd(m_addr); memop = 1;
        wr(ins[8:6], m_ld);
      end
      4'h1: begin
        m_addr = x + im; m_we = 1; m_wdata = y;
        dm[m_addr] = y; memop = 1;
      end
      4'h2: begin wr(ins[5:3], f_alu(ins[2:0], x, y)); base = 4; end
      4'h3: begin wr(ins[8:6], x + im); base = 4; end
      4'hf: hlt = 1;
      default: ;
    endcase
    m_pc = f_npc(m_pc, ins, x == y);
    if (memop) begin
      mem_at = cyc + 3;
      dw = pick_dw();
    end else if (hlt) begin
      halt_at = cyc + 3;
      ret_at = cyc + 3;
    end else begin
      fetch_at = cyc + base;
      ret_at = fetch_at;
      iw = pick_iw();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic eval();
    bit ei, ed;
    logic [15:0] ins;
    logic [31:0] e;
    if (ret_at >= 0 && cyc >= ret_at) begin exp_ret++; ret_at = -1; end
    if (halt_at >= 0 && cyc >= halt_at) begin halt_m = 1; halt_at = -1; end
    ei = !halt_m && fetch_at >= 0 && cyc >= fetch_at;
    ed = mem_at >= 0 && cyc >= mem_at;
    chk("imem_req", 32'(bus.imem_req), 32'(ei));
    chk("dmem_req", 32'(bus.dmem_req), 32'(ed));
    chk("retired", retired, exp_ret);
    chk("halted", 32'(halted), 32'(halt_m));
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.imem_rdata = 16'($urandom);
    bus.dmem_rdata = 16'($urandom);
    if (halt_m) chk("halt_pc", 32'(pc), 32'(m_pc));
    if (ei) begin
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("pc", 32'(pc), 32'(m_pc));
      if (iw > 0) iw--;
      else begin
        ins = imem[m_pc[12:1]];
        bus.imem_ack = 1'b1;
        bus.imem_rdata = ins;
        if (directed && lit_fetch.size() > 0)
          chk("lit_fetch", 32'(bus.imem_addr), 32'(lit_fetch.pop_front()));
        fetch_at = -1;
        model_exec(ins);
      end
    end
    if (ed) begin
      chk("dmem_we", 32'(bus.dmem_we), 32'(m_we));
      chk("dmem_addr", 32'(bus.dmem_addr), 32'(m_addr));
      chk("dmem_wdata", 32'(bus.dmem_wdata), 32'(m_wdata));
      if (mid_rst_req && dw > 0) mid_fire = 1;
      else if (dw > 0) dw--;
      else begin
        bus.dmem_ack = 1'b1;
        if (!m_we) bus.dmem_rdata = m_ld;
        if (directed && m_we && lit_st.size() > 0) begin
          e = lit_st.pop_front();
          chk("lit_st_addr", 32'(bus.dmem_addr), 32'(e[31:16]));
          chk("lit_st_data", 32'(bus.dmem_wdata), 32'(e[15:0]));
        end
        mem_at = -1;
        fetch_at = cyc + (m_we ? 1 : 2);
        ret_at = fetch_at;
        iw = pick_iw();
      end
    end
  endtask

  task automatic do_reset(input int k);
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < k; i++) begin
      tick();
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mr[i] = '0;
    m_pc = '0;
    exp_ret = '0;
    halt_m = 0;
    fetch_at = cyc + 1;
    mem_at = -1;
    ret_at = -1;
    halt_at = -1;
    iw = pick_iw();
  endtask

  initial begin
    logic [15:0] prog [17];
    int c0, hc;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_rdata = '0;
    mid_rst_req = 0;
    mid_fire = 0;

    chk("pin_jmp", 32'(f_npc(16'he000, 16'hd010, 0)), 32'h e020);
    chk("pin_beq", 32'(f_npc(16'h0004, 16'hb27f, 1)), 32'h0004);
    chk("pin_bne", 32'(f_npc(16'h0004, 16'hc243, 1)), 32'h0006);
    chk("pin_sub", 32'(f_alu(3'd1, 16'h0000, 16'h0001)), 32'h ffff);
    chk("pin_slt", 32'(f_alu(3'd5, 16'h8000, 16'h0001)), 32'h0001);

    prog = '{16'h3045, 16'h2250, 16'h1083, 16'h00c3, 16'h3141,
             16'h2161, 16'h10c4, 16'h1105, 16'h0186, 16'h2d7d,
             16'h11c7, 16'h3205, 16'h1008, 16'hc243, 16'hb241,
             16'h1049, 16'hd020};
    for (int i = 0; i < 4096; i++) imem[i] = 16'hf000;
    for (int i = 0; i < 17; i++) imem[i] = prog[i];
    dm[16'h0006] = 16'h8000;
    for (int i = 0; i < 15; i++) lit_fetch.push_back(16'(2 * i));
    lit_fetch.push_back(16'h0020);
    lit_fetch.push_back(16'h0040);
    lit_st = '{{16'd3, 16'd10}, {16'd4, 16'd10}, {16'd5, 16'hffff},
               {16'd7, 16'd1}, {16'd8, 16'd0}};
    directed = 1;

    do_reset(2);
    c0 = cyc;
    hc = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      eval();
      if (cyc == c0 + 9) begin
        chk("lit_ret2", retired, 32'd2);
        chk("lit_addr4", 32'(bus.imem_addr), 32'd4);
      end
      if (halt_m) hc++;
      if (hc > 4) break;
    end
    chk("lit_halt_ret", retired, 32'd17);
    chk("lit_halted", 32'(halted), 32'd1);
    chk("lit_halt_pc", 32'(pc), 32'h40);
    chk("lit_fetch_left", 32'(lit_fetch.size()), 32'd0);
    chk("lit_st_left", 32'(lit_st.size()), 32'd0);

    directed = 0;
    mid_rst_req = 1;
    for (int s = 0; s < 40 && cyc < 30000; s++) begin
      for (int i = 0; i < 4096; i++) imem[i] = rnd_ins();
      do_reset(1 + s % 2);
      hc = 0;
      for (int i = 0; i < 2000; i++) begin
        tick();
        eval();
        if (mid_fire) begin
          mid_fire = 0;
          mid_rst_req = 0;
          do_reset(1);
        end
        if (halt_m) hc++;
        if (hc > 4) break;
      end
    end
    chk("mid_mem_reset_seen", 32'(mid_rst_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle successor of the 16-bit single-cycle datapath.
- Integrated control FSM; data width and PC width are parameters; instruction encoding is unchanged.
- Instruction and data memories sit outside the block and are reached through req/ack handshake ports, so wait-state memories can stall the core.
- Adds a HALT state and a retired-instruction counter.

Parameters:
DATA_W, 16, register/ALU/data-memory width (>=16)
PC_W, 16, program counter and instruction address width (>=14)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  instruction fetch request
imem_addr  output  PC_W  fetch address (equals pc)
imem_rdata  input  16  instruction word
imem_ack  input  1  fetch complete, imem_rdata valid this cycle
dmem_req  output  1  data access request
dmem_we  output  1  1 = store, 0 = load
dmem_addr  output  DATA_W  ALU result latched in EXEC
dmem_wdata  output  DATA_W  rt operand
dmem_rdata  input  DATA_W  load data
dmem_ack  input  1  access complete, dmem_rdata valid this cycle on loads
pc  output  PC_W  current PC
halted  output  1  core is in HALT
retired  output  32  count of completed instructions, wraps at 2^32

Behaviour:
- Reset (overrides everything, including mid-access):
  - State goes to FETCH; pc=RESET_PC; all 8 registers cleared; retired=0; halted=0.
  - All req outputs are 0 during the reset cycle.
  - An outstanding ack after reset is ignored unless it arrives while the new FETCH request is active.
- Encoding:
  - op=[15:12], rs=[11:9], rt=[8:6], rd=[5:3], funct=[2:0], imm6=[5:0] sign-extended to DATA_W, imm12=[11:0].
- Opcodes:
  - 0000 LW: rt <= M[rs+imm]
  - 0001 SW: M[rs+imm] <= rt
  - 0010 R-type: rd <= rs op rt
  - 0011 ADDI: rt <= rs+imm
  - 1011 BEQ, 1100 BNE
  - 1101 JMP
  - 1111 HALT
  - All other opcodes are a NOP.
- R-type funct: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed slt (result 1/0), 110 shl by 1, 111 logical shr by 1. All arithmetic is modulo 2^DATA_W.
- r0 reads as 0; writes to r0 are discarded.
- FSM: FETCH -> DECODE -> EXEC -> {MEM -> WB | WB | FETCH}; HALT.
  - FETCH: imem_req=1, held with a stable address until imem_ack. On ack, IR is latched and state goes to DECODE. Ack may arrive in the first request cycle.
  - DECODE: latch A=R[rs], B=R[rt].
  - EXEC:
    - Latch ALU result.
    - BEQ/BNE: pc <= pc+2+(imm6<<1) if taken, else pc+2; then FETCH.
    - JMP: pc <= {pc2[PC_W-1:13], imm12, 1'b0}; then FETCH.
    - NOP: pc+2; then FETCH.
    - LW/SW: go to MEM. R/ADDI: go to WB.
    - HALT: go to HALT, halted=1.
  - MEM:
    - dmem_req=1, with dmem_addr, dmem_we and dmem_wdata held stable until dmem_ack.
    - SW on ack: pc+2, then FETCH.
    - LW on ack: latch rdata, then WB.
  - WB: register write, pc+2, then FETCH.
- retired increments by 1 in the cycle each instruction leaves its final state (EXEC, MEM, or WB). HALT counts once, on entering HALT.
- HALT: no requests; pc, registers and retired are frozen; exit only via rst.
- Latency with zero-wait memory (ack in the first request cycle):
  - R/ADDI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - branch/jump/NOP: 3 cycles
- Each wait cycle adds exactly 1 cycle.
- imem_req and dmem_req are never high together.
- PC wraps modulo 2^PC_W.

Test Plan:
- Reset, then R-type: rst high 2 cycles, release; memory returns ADDI r1,r0,5 then ADD r2,r1,r1 with zero wait -> r2=10; retired=2 after 8 cycles; imem_addr sequence 0,2.
- Store/load with waits: SW r2,3(r0), then LW r3,3(r0); dmem_ack delayed 3 cycles -> dmem_addr=3, wdata=10 stable throughout the wait; r3=10; LW takes 8 cycles.
- Branch offsets: BEQ r1,r1,-2 at pc=4 -> next pc=4. BNE r1,r1,+3 -> pc+2 (not taken).
- Jump: JMP imm12=0x010 at pc=0xE000 -> pc=0xE020.
- ALU edge cases: SUB 0-1 -> 0xFFFF (DATA_W=16). SLT with 0x8000 vs 1 -> 1. Write to r0 -> r0 still reads 0.
- HALT then reset:
  - HALT -> halted=1 and no req thereafter.
  - Reset asserted mid-MEM (dmem_req high, ack low) -> next cycle dmem_req=0, pc=RESET_PC, retired=0.
